// File: rtl/regfile_rw_pkg.sv
//==============================================================================
// regfile_rw_pkg : shared widths, bus types and debug FSM encoding (Rev 1.0)
//==============================================================================
`default_nettype none

package regfile_rw_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;
   localparam int ZERO_REG   = 0;

   typedef logic [REG_ADDR_W-1:0] RegAddrBus;
   typedef logic [REG_DATA_W-1:0] RegDataBus;

   typedef enum logic [1:0] {
      DBG_IDLE   = 2'd0,
      DBG_ACCESS = 2'd1,
      DBG_ACK    = 2'd2
   } dbg_state_e;

endpackage : regfile_rw_pkg

`default_nettype wire

// File: rtl/regfile_bypass_rd.sv
//==============================================================================
// regfile_bypass_rd : one read port with x0 masking and WB write-through bypass
// Rev 1.0
//==============================================================================
`default_nettype none

module regfile_bypass_rd #(
   parameter int REG_ADDR_W = regfile_rw_pkg::REG_ADDR_W,
   parameter int REG_DATA_W = regfile_rw_pkg::REG_DATA_W
) (
   input  logic [REG_ADDR_W-1:0] rd_addr_i,
   input  logic [REG_DATA_W-1:0] arr_data_i,
   input  logic                  wb_wreg_en_i,
   input  logic [REG_ADDR_W-1:0] wb_wreg_addr_i,
   input  logic [REG_DATA_W-1:0] wb_wreg_data_i,
   output logic [REG_DATA_W-1:0] rd_data_o
);
   import regfile_rw_pkg::*;

   always_comb begin
      rd_data_o = arr_data_i;
      if (rd_addr_i == REG_ADDR_W'(ZERO_REG)) begin
         rd_data_o = '0;
      end else if (wb_wreg_en_i && (wb_wreg_addr_i == rd_addr_i)) begin
         rd_data_o = wb_wreg_data_i;
      end
   end

endmodule : regfile_bypass_rd

`default_nettype wire

// File: rtl/regfile_rw.sv
//==============================================================================
// regfile_rw : 32x32 GPR file, two bypassed ID read ports, WB write, debug port
// Rev 1.0
//==============================================================================
`default_nettype none

module regfile_rw #(
   parameter int REG_ADDR_W  = regfile_rw_pkg::REG_ADDR_W,
   parameter int REG_DATA_W  = regfile_rw_pkg::REG_DATA_W,
   parameter int RESET_CLEAR = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wb_wreg_en_i,
   input  logic [REG_ADDR_W-1:0] wb_wreg_addr_i,
   input  logic [REG_DATA_W-1:0] wb_wreg_data_i,
   input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
   input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
   output logic [REG_DATA_W-1:0] id_rs1_data_o,
   output logic [REG_DATA_W-1:0] id_rs2_data_o,
   input  logic                  dbg_req_i,
   input  logic                  dbg_we_i,
   input  logic [REG_ADDR_W-1:0] dbg_addr_i,
   input  logic [REG_DATA_W-1:0] dbg_wdata_i,
   output logic                  dbg_ack_o,
   output logic [REG_DATA_W-1:0] dbg_rdata_o,
   output logic                  wb_block_o
);
   import regfile_rw_pkg::*;

   localparam int NUM_REGS = 1 << REG_ADDR_W;

   dbg_state_e              state_q, state_d;
   logic                    dbg_we_q;
   logic [REG_ADDR_W-1:0]   dbg_addr_q;
   logic [REG_DATA_W-1:0]   dbg_wdata_q;
   logic [REG_DATA_W-1:0]   dbg_rdata_q;
   logic [REG_DATA_W-1:0]   dbg_rd_val;
   logic                    dbg_wr_en;
   logic [REG_DATA_W-1:0]   regs [NUM_REGS];

   assign dbg_wr_en = (state_q == DBG_ACCESS) && dbg_we_q;

   // x0 has no storage; writes to index 0 therefore vanish on their own.
   assign regs[0] = '0;

   for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      logic [REG_DATA_W-1:0] reg_q;
      always_ff @(posedge clk) begin
         if (rst) begin
            if (RESET_CLEAR != 0) reg_q <= '0;
         end else if (dbg_wr_en && (dbg_addr_q == REG_ADDR_W'(gi))) begin
            reg_q <= dbg_wdata_q;
         end else if (wb_wreg_en_i && (wb_wreg_addr_i == REG_ADDR_W'(gi))) begin
            reg_q <= wb_wreg_data_i;
         end
      end
      assign regs[gi] = reg_q;
   end

   regfile_bypass_rd #(.REG_ADDR_W(REG_ADDR_W), .REG_DATA_W(REG_DATA_W)) u_rd_rs1 (
      .rd_addr_i      (id_rs1_addr_i),
      .arr_data_i     (regs[id_rs1_addr_i]),
      .wb_wreg_en_i   (wb_wreg_en_i),
      .wb_wreg_addr_i (wb_wreg_addr_i),
      .wb_wreg_data_i (wb_wreg_data_i),
      .rd_data_o      (id_rs1_data_o)
   );

   regfile_bypass_rd #(.REG_ADDR_W(REG_ADDR_W), .REG_DATA_W(REG_DATA_W)) u_rd_rs2 (
      .rd_addr_i      (id_rs2_addr_i),
      .arr_data_i     (regs[id_rs2_addr_i]),
      .wb_wreg_en_i   (wb_wreg_en_i),
      .wb_wreg_addr_i (wb_wreg_addr_i),
      .wb_wreg_data_i (wb_wreg_data_i),
      .rd_data_o      (id_rs2_data_o)
   );

   // Debug reads see a same-cycle WB write, just like the ID ports.
   regfile_bypass_rd #(.REG_ADDR_W(REG_ADDR_W), .REG_DATA_W(REG_DATA_W)) u_rd_dbg (
      .rd_addr_i      (dbg_addr_q),
      .arr_data_i     (regs[dbg_addr_q]),
      .wb_wreg_en_i   (wb_wreg_en_i),
      .wb_wreg_addr_i (wb_wreg_addr_i),
      .wb_wreg_data_i (wb_wreg_data_i),
      .rd_data_o      (dbg_rd_val)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         DBG_IDLE:   if (dbg_req_i) state_d = DBG_ACCESS;
         DBG_ACCESS: state_d = DBG_ACK;
         DBG_ACK:    state_d = DBG_IDLE;
         default:    state_d = DBG_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= DBG_IDLE;
         dbg_we_q    <= 1'b0;
         dbg_addr_q  <= '0;
         dbg_wdata_q <= '0;
         dbg_rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if ((state_q == DBG_IDLE) && dbg_req_i) begin
            dbg_we_q    <= dbg_we_i;
            dbg_addr_q  <= dbg_addr_i;
            dbg_wdata_q <= dbg_wdata_i;
         end
         if ((state_q == DBG_ACCESS) && !dbg_we_q) dbg_rdata_q <= dbg_rd_val;
      end
   end

   assign dbg_ack_o   = (state_q == DBG_ACK);
   assign dbg_rdata_o = dbg_rdata_q;
   assign wb_block_o  = dbg_wr_en;

   // The pipeline is halted during debug, so WB must not target the debug write index.
   a_no_wb_collision : assert property (@(posedge clk) disable iff (rst)
      !(dbg_wr_en && wb_wreg_en_i && (wb_wreg_addr_i == dbg_addr_q)
        && (wb_wreg_addr_i != REG_ADDR_W'(ZERO_REG))));

endmodule : regfile_rw

`default_nettype wire

// File: tb/tb_regfile_rw.sv
//==============================================================================
// tb_regfile_rw : table vectors, debug-port sequences and randomized traffic
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_regfile_rw;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic [4:0]  rs1, rs2;
   logic [31:0] rs1_data, rs2_data;
   logic        dbg_req, dbg_we;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_wdata;
   logic        dbg_ack;
   logic [31:0] dbg_rdata;
   logic        wb_block;

   int checks = 0;
   int errors = 0;

   logic [31:0] model [32];

   always #5 clk = ~clk;

   regfile_rw #(.REG_ADDR_W(5), .REG_DATA_W(32), .RESET_CLEAR(1)) dut (
      .clk            (clk),
      .rst            (rst),
      .wb_wreg_en_i   (wb_en),
      .wb_wreg_addr_i (wb_addr),
      .wb_wreg_data_i (wb_data),
      .id_rs1_addr_i  (rs1),
      .id_rs2_addr_i  (rs2),
      .id_rs1_data_o  (rs1_data),
      .id_rs2_data_o  (rs2_data),
      .dbg_req_i      (dbg_req),
      .dbg_we_i       (dbg_we),
      .dbg_addr_i     (dbg_addr),
      .dbg_wdata_i    (dbg_wdata),
      .dbg_ack_o      (dbg_ack),
      .dbg_rdata_o    (dbg_rdata),
      .wb_block_o     (wb_block)
   );

   typedef struct {
      logic        en;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic [31:0] e1;
      logic [31:0] e2;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected read value from the architectural rules and current WB inputs.
   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (wb_en && wb_addr == a) return wb_data;
      return model[a];
   endfunction

   task automatic commit_wb();
      if (wb_en && wb_addr != 5'd0) model[wb_addr] = wb_data;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
   endtask

   task automatic read_cycle(input logic [4:0] a1, input logic [4:0] a2, input string name);
      @(posedge clk); #1;
      wb_en = 1'b0; rs1 = a1; rs2 = a2;
      @(negedge clk);
      chk({name, "_rs1"}, rs1_data, exp_rd(a1));
      chk({name, "_rs2"}, rs2_data, exp_rd(a2));
   endtask

   task automatic dbg_op(input logic we, input logic [4:0] a, input logic [31:0] wd,
                         input logic wbx, input logic [4:0] wa, input logic [31:0] wdat);
      logic [31:0] exp;
      @(posedge clk); #1;
      wb_en = 1'b0;
      dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = wd;
      @(negedge clk);
      chk("dbg_ack_idle", {31'd0, dbg_ack}, 32'd0);
      @(posedge clk); #1;
      if (wbx) begin wb_en = 1'b1; wb_addr = wa; wb_data = wdat; end
      @(negedge clk);
      chk("dbg_block_access", {31'd0, wb_block}, {31'd0, we});
      chk("dbg_ack_access", {31'd0, dbg_ack}, 32'd0);
      exp = exp_rd(a);
      commit_wb();
      if (we && a != 5'd0) model[a] = wd;
      @(posedge clk); #1;
      wb_en = 1'b0;
      @(negedge clk);
      chk("dbg_ack_pulse", {31'd0, dbg_ack}, 32'd1);
      chk("dbg_block_ack", {31'd0, wb_block}, 32'd0);
      if (!we) chk("dbg_rdata", dbg_rdata, exp);
      dbg_req = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("dbg_ack_done", {31'd0, dbg_ack}, 32'd0);
   endtask

   initial begin
      vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0};
      vecs[1] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF};
      vecs[2] = '{1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 32'h0,        32'h0};
      vecs[3] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 32'h0,        32'h0};
      vecs[4] = '{1'b1, 5'd3, 32'h11,       5'd3, 5'd0, 32'h11,       32'h0};
      vecs[5] = '{1'b1, 5'd4, 32'h22,       5'd3, 5'd4, 32'h11,       32'h22};
      vecs[6] = '{1'b0, 5'd0, 32'h0,        5'd4, 5'd4, 32'h22,       32'h22};
      vecs[7] = '{1'b1, 5'd4, 32'h33,       5'd4, 5'd3, 32'h33,       32'h11};
      vecs[8] = '{1'b0, 5'd0, 32'h0,        5'd4, 5'd5, 32'h33,       32'hDEADBEEF};

      rst = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0; rs1 = '0; rs2 = '0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
      clear_model();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ack", {31'd0, dbg_ack}, 32'd0);
      chk("rst_rdata", dbg_rdata, 32'd0);
      chk("rst_block", {31'd0, wb_block}, 32'd0);
      for (int i = 1; i < 32; i++) read_cycle(5'(i), 5'(32 - i), "rst_clear");

      for (int i = 0; i < 9; i++) begin
         @(posedge clk); #1;
         wb_en = vecs[i].en; wb_addr = vecs[i].wa; wb_data = vecs[i].wd;
         rs1 = vecs[i].a1; rs2 = vecs[i].a2;
         @(negedge clk);
         chk($sformatf("vec%0d_rs1", i), rs1_data, vecs[i].e1);
         chk($sformatf("vec%0d_rs2", i), rs2_data, vecs[i].e2);
         commit_wb();
      end

      // Debug read of x7, plain and with a same-index WB write during ACCESS.
      @(posedge clk); #1;
      wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hA5A5A5A5;
      @(negedge clk);
      commit_wb();
      dbg_op(1'b0, 5'd7, 32'h0, 1'b0, 5'd0, 32'h0);
      chk("dbg_rd_x7_const", dbg_rdata, 32'hA5A5A5A5);
      dbg_op(1'b0, 5'd7, 32'h0, 1'b1, 5'd7, 32'h1);
      chk("dbg_rd_x7_bypass_const", dbg_rdata, 32'h1);

      // Debug write x9, WB writing another index concurrently, then x0.
      dbg_op(1'b1, 5'd9, 32'hCAFE, 1'b1, 5'd10, 32'h5555);
      read_cycle(5'd9, 5'd10, "after_dbg_wr");
      chk("x9_cafe_const", rs1_data, 32'hCAFE);
      dbg_op(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'h0);
      read_cycle(5'd0, 5'd9, "after_dbg_wr_x0");

      // Requests held high: one ack every three cycles.
      @(posedge clk); #1;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd3;
      for (int k = 0; k < 9; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk($sformatf("b2b_ack%0d", k), {31'd0, dbg_ack}, {31'd0, (k % 3) == 1});
         if (dbg_ack) chk("b2b_rdata", dbg_rdata, model[3]);
      end
      dbg_req = 1'b0;

      // Reset lands while a debug write is in ACCESS.
      @(posedge clk); #1;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'hBEEF;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid_block", {31'd0, wb_block}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b0; dbg_req = 1'b0;
      clear_model();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rstmid_no_ack", {31'd0, dbg_ack}, 32'd0);
         chk("rstmid_no_block", {31'd0, wb_block}, 32'd0);
         @(posedge clk); #1;
      end
      read_cycle(5'd9, 5'd3, "rstmid_cleared");
      chk("rstmid_rdata", dbg_rdata, 32'd0);

      // Randomized WB traffic on both read ports against the reference model.
      for (int n = 0; n < 300; n++) begin
         @(posedge clk); #1;
         wb_en = 1'($urandom_range(0, 1));
         wb_addr = 5'($urandom_range(0, 31));
         wb_data = $urandom;
         rs1 = ($urandom_range(0, 3) == 0) ? wb_addr : 5'($urandom_range(0, 31));
         rs2 = 5'($urandom_range(0, 31));
         @(negedge clk);
         chk("rand_rs1", rs1_data, exp_rd(rs1));
         chk("rand_rs2", rs2_data, exp_rd(rs2));
         commit_wb();
      end

      // Randomized debug accesses with optional concurrent WB writes.
      for (int n = 0; n < 30; n++) begin
         logic        we;
         logic [4:0]  a, wa;
         we = 1'($urandom_range(0, 1));
         a  = 5'($urandom_range(0, 31));
         wa = 5'($urandom_range(0, 31));
         if (we && wa == a) wa = a + 5'd1;
         dbg_op(we, a, $urandom, 1'($urandom_range(0, 1)), wa, $urandom);
         read_cycle(a, wa, "rand_dbg_after");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_regfile_rw

`default_nettype wire
